hub75_scanner: RTL

HUB75_SCANNER -- requirements
Module: hub75_scanner

---
 rtl/hub75_pkg.sv | 28 ++
 rtl/hub75_oe_timer.sv | 55 +++++
 rtl/hub75_scanner.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// Shared constants, FSM state type and brightness helper for the HUB75 row scanner.
package hub75_pkg;

    localparam int unsigned PANEL_COLS      = 64;
    localparam int unsigned PANEL_ROWS_HALF = 16;
    localparam int unsigned COL_W           = $clog2(PANEL_COLS);
    localparam int unsigned ROW_W           = $clog2(PANEL_ROWS_HALF);
    localparam int unsigned FB_ADDR_W       = 1 + ROW_W + COL_W;
    localparam int unsigned PIX_W           = 6;
    localparam int unsigned ON_W            = 16;
    localparam int unsigned BRIGHT_W        = 8;
    // Two prefetch cycles ahead of the 2-cycle-per-column shift.
    localparam int unsigned SHIFT_CYCLES    = 2 * PANEL_COLS + 2;
    localparam int unsigned SHIFT_CNT_W     = $clog2(SHIFT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_DISPLAY
    } state_e;

    function automatic logic [ON_W-1:0] dim_on_cycles(input logic [ON_W-1:0]     on_time,
                                                      input logic [BRIGHT_W-1:0] bright);
        return ON_W'((32'(on_time) * 32'(bright)) >> 8);
    endfunction

endpackage

// File: rtl/hub75_oe_timer.sv
// DISPLAY window timer: counts ON_TIME cycles and drives OEb low for the lit part.
// With HUB75_DIM_EN the lit part shrinks to (ON_TIME*bright_i)>>8 cycles.
module hub75_oe_timer
    import hub75_pkg::*;
#(
    parameter int unsigned ON_TIME = 256
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
`ifdef HUB75_DIM_EN
    input  logic [BRIGHT_W-1:0] bright_i,
`endif
    output logic                oeb_o,
    output logic                last_o
);

    logic [ON_W-1:0] cnt_q;
    logic [ON_W-1:0] on_q;
    logic [ON_W-1:0] on_load;
    logic            oeb_q;
    logic            last_q;

`ifdef HUB75_DIM_EN
    assign on_load = dim_on_cycles(ON_W'(ON_TIME), bright_i);
`else
    assign on_load = ON_W'(ON_TIME);
`endif

    // oeb_q/last_q are computed one cycle ahead so both leave here registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            on_q   <= '0;
            oeb_q  <= 1'b1;
            last_q <= 1'b0;
        end else if (load_i) begin
            cnt_q  <= ON_W'(ON_TIME);
            on_q   <= on_load;
            oeb_q  <= (on_load == '0);
            last_q <= (ON_TIME == 1);
        end else if (cnt_q != '0) begin
            cnt_q  <= cnt_q - ON_W'(1);
            if (on_q != '0) begin
                on_q <= on_q - ON_W'(1);
            end
            oeb_q  <= (cnt_q <= ON_W'(1)) || (on_q <= ON_W'(1));
            last_q <= (cnt_q == ON_W'(2));
        end
    end

    assign oeb_o  = oeb_q;
    assign last_o = last_q;

endmodule

// File: rtl/hub75_scanner.sv
// HUB75 panel row scanner: fetches a row from the framebuffer, shifts, latches, displays.
// Optional macro HUB75_DIM_EN adds bright_i for PWM dimming of the display window.
module hub75_scanner
    import hub75_pkg::*;
#(
    parameter int unsigned ON_TIME = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 buf_sel_i,
    output logic [FB_ADDR_W-1:0] fb_addr_o,
    input  logic [PIX_W-1:0]     fb_data_i,
`ifdef HUB75_DIM_EN
    input  logic [BRIGHT_W-1:0]  bright_i,
`endif
    output logic                 r1_o,
    output logic                 g1_o,
    output logic                 b1_o,
    output logic                 r2_o,
    output logic                 g2_o,
    output logic                 b2_o,
    output logic                 pclk_o,
    output logic                 stb_o,
    output logic                 oeb_o,
    output logic [ROW_W-1:0]     addr_o,
    output logic                 frame_done_o
);

    state_e                 state_q;
    logic                   buf_q;
    logic [ROW_W-1:0]       row_q;
    logic [COL_W-1:0]       col_q;
    logic [SHIFT_CNT_W-1:0] cnt_q;
    logic [PIX_W-1:0]       pix_q;
    logic                   pclk_q;
    logic                   stb_q;
    logic [ROW_W-1:0]       addr_q;
    logic                   frame_done_q;
    logic                   disp_last;
    logic                   latch_c;

    assign latch_c = (state_q == ST_LATCH);

    hub75_oe_timer #(
        .ON_TIME (ON_TIME)
    ) u_oe_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (latch_c),
`ifdef HUB75_DIM_EN
        .bright_i (bright_i),
`endif
        .oeb_o    (oeb_o),
        .last_o   (disp_last)
    );

    // Shift cycle k: address col k/2 is presented, its data arrives in cycle k+1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            buf_q        <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            cnt_q        <= '0;
            pix_q        <= '0;
            pclk_q       <= 1'b0;
            stb_q        <= 1'b0;
            addr_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_q <= ST_SHIFT;
                        buf_q   <= buf_sel_i;
                        row_q   <= '0;
                        col_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                ST_SHIFT: begin
                    cnt_q <= cnt_q + SHIFT_CNT_W'(1);
                    if (cnt_q[0] && (col_q != COL_W'(PANEL_COLS - 1))) begin
                        col_q <= col_q + COL_W'(1);
                    end
                    if (cnt_q[0] && (cnt_q < SHIFT_CNT_W'(2 * PANEL_COLS))) begin
                        pix_q <= fb_data_i;
                    end
                    pclk_q <= ~cnt_q[0] && (cnt_q >= SHIFT_CNT_W'(2));
                    if (cnt_q == SHIFT_CNT_W'(SHIFT_CYCLES - 1)) begin
                        state_q <= ST_LATCH;
                        stb_q   <= 1'b1;
                        addr_q  <= row_q;
                    end
                end
                ST_LATCH: begin
                    stb_q   <= 1'b0;
                    state_q <= ST_DISPLAY;
                end
                ST_DISPLAY: begin
                    if (disp_last) begin
                        col_q <= '0;
                        cnt_q <= '0;
                        if (row_q == ROW_W'(PANEL_ROWS_HALF - 1)) begin
                            frame_done_q <= 1'b1;
                        end
                        if (enable_i) begin
                            state_q <= ST_SHIFT;
                            row_q   <= row_q + ROW_W'(1);
                            if (row_q == ROW_W'(PANEL_ROWS_HALF - 1)) begin
                                buf_q <= buf_sel_i;
                            end
                        end else begin
                            state_q <= ST_IDLE;
                            row_q   <= '0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fb_addr_o    = {buf_q, row_q, col_q};
    assign {r1_o, g1_o, b1_o, r2_o, g2_o, b2_o} = pix_q;
    assign pclk_o       = pclk_q;
    assign stb_o        = stb_q;
    assign addr_o       = addr_q;
    assign frame_done_o = frame_done_q;

endmodule
